// File: rtl/ram_req_ctrl.sv
// Request/response front end for a synchronous-read single-port RAM with an in-order response FIFO.
// Optional build macro RAM_REQ_CTRL_WR_ACK_EN: writes also return an acknowledge response.
module ram_req_ctrl #(
    parameter int AWIDTH    = 3,
    parameter int DWIDTH    = 32,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_data,
    output logic [AWIDTH-1:0] rsp_addr,
    output logic              rsp_is_wr,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_din,
    output logic              ram_we,
    input  logic [DWIDTH-1:0] ram_dout
);

    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic              inflight_q, inflight_d;
    logic [AWIDTH-1:0] infl_addr_q, infl_addr_d;
    logic [AWIDTH-1:0] addr_hold_q, addr_hold_d;

    logic [DWIDTH-1:0] fifo_data_q [RSP_DEPTH];
    logic [AWIDTH-1:0] fifo_addr_q [RSP_DEPTH];

`ifdef RAM_REQ_CTRL_WR_ACK_EN
    logic              infl_wr_q, infl_wr_d;
    logic [DWIDTH-1:0] infl_wdata_q, infl_wdata_d;
    logic              fifo_wr_q [RSP_DEPTH];
`endif

    logic              accept;
    logic              push;
    logic              pop;
    logic [CW:0]       occupancy;
    logic [DWIDTH-1:0] push_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit covers both buffered entries and the one still in the RAM pipeline,
    // so a push can never find the FIFO full; registered state only.
    assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign req_ready = reset_n & (occupancy < (CW+1)'(RSP_DEPTH));
    assign accept    = req_valid & req_ready;
    assign push      = inflight_q;
    assign rsp_valid = (count_q != '0);
    assign pop       = rsp_valid & rsp_ready;

    assign ram_we   = accept & req_we;
    assign ram_din  = req_wdata;
    assign ram_addr = accept ? req_addr : addr_hold_q;

`ifdef RAM_REQ_CTRL_WR_ACK_EN
    assign push_data = infl_wr_q ? infl_wdata_q : ram_dout;
`else
    assign push_data = ram_dout;
`endif

    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    always_comb begin
        inflight_d  = 1'b0;
        infl_addr_d = infl_addr_q;
        addr_hold_d = addr_hold_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
`ifdef RAM_REQ_CTRL_WR_ACK_EN
        infl_wr_d    = infl_wr_q;
        infl_wdata_d = infl_wdata_q;
`endif

        if (accept) begin
            addr_hold_d = req_addr;
            infl_addr_d = req_addr;
`ifdef RAM_REQ_CTRL_WR_ACK_EN
            inflight_d   = 1'b1;
            infl_wr_d    = req_we;
            infl_wdata_d = req_wdata;
`else
            inflight_d   = ~req_we;
`endif
        end

        if (push) wptr_d = ptr_inc(wptr_q);
        if (pop)  rptr_d = ptr_inc(rptr_q);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            inflight_q  <= 1'b0;
            infl_addr_q <= '0;
            addr_hold_q <= '0;
`ifdef RAM_REQ_CTRL_WR_ACK_EN
            infl_wr_q    <= 1'b0;
            infl_wdata_q <= '0;
`endif
        end else begin
            count_q     <= count_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            inflight_q  <= inflight_d;
            infl_addr_q <= infl_addr_d;
            addr_hold_q <= addr_hold_d;
`ifdef RAM_REQ_CTRL_WR_ACK_EN
            infl_wr_q    <= infl_wr_d;
            infl_wdata_q <= infl_wdata_d;
`endif
        end
    end

    // NOTE: FIFO storage has no reset; count_q gates visibility, so stale entries are never seen.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_data_q[wptr_q] <= push_data;
            fifo_addr_q[wptr_q] <= infl_addr_q;
`ifdef RAM_REQ_CTRL_WR_ACK_EN
            fifo_wr_q[wptr_q]   <= infl_wr_q;
`endif
        end
    end

    assign rsp_data = rsp_valid ? fifo_data_q[rptr_q] : '0;
    assign rsp_addr = rsp_valid ? fifo_addr_q[rptr_q] : '0;
`ifdef RAM_REQ_CTRL_WR_ACK_EN
    assign rsp_is_wr = rsp_valid ? fifo_wr_q[rptr_q] : 1'b0;
`else
    assign rsp_is_wr = 1'b0;
`endif

endmodule

// File: doc/ram_req_ctrl.md
Name: ram_req_ctrl

Overview:
Initiator-side controller for a single-port synchronous-read RAM with one address port, separate din/dout, and write enable. Address and write are sampled on the rising clock edge; read data appears the cycle after the address edge. The block accepts requests over a valid/ready interface and drives the RAM port. It captures read data with the RAM's one-cycle latency and returns in-order responses through a response FIFO with backpressure. It sits between a bus master and the data RAM instance.

Parameters:
AWIDTH, 3, address width; RAM depth is 2^AWIDTH.
DWIDTH, 32, data width.
RSP_DEPTH, 4, response FIFO entries; minimum 2, any integer.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset_n  input  1  asynchronous active-low reset.
req_valid  input  1  request present.
req_ready  output  1  controller can accept a request this cycle.
req_we  input  1  1 = write, 0 = read.
req_addr  input  AWIDTH  request address.
req_wdata  input  DWIDTH  write data.
rsp_valid  output  1  response available at FIFO head.
rsp_ready  input  1  consumer takes the response.
rsp_data  output  DWIDTH  read data, or write data when acknowledging a write.
rsp_addr  output  AWIDTH  address echo of the response.
rsp_is_wr  output  1  response is a write acknowledge; tied 0 without the optional feature.
ram_addr  output  AWIDTH  to RAM addr.
ram_din  output  DWIDTH  to RAM din; equals req_wdata.
ram_we  output  1  to RAM we.
ram_dout  input  DWIDTH  from RAM dout.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - FIFO count, read/write pointers and the inflight flag clear to 0.
  - addr_hold clears to 0.
  - rsp_valid=0, req_ready=0, ram_we=0, rsp_data/rsp_addr/rsp_is_wr=0.
  - RAM contents are untouched.
- Reset mid-operation: the inflight operation and all buffered responses are discarded silently.
- A request is accepted when req_valid and req_ready are both 1 at a rising edge.
- req_ready = reset_n and (count + inflight < RSP_DEPTH).
  - It is computed from registered state only; a same-cycle pop gives no credit.
  - There is no combinational path from rsp_ready to req_ready.
- RAM drive (combinational):
  - ram_we = req_valid & req_ready & req_we.
  - ram_addr = req_addr on an accepting cycle; otherwise addr_hold, the last accepted address.
  - This keeps the RAM's latched read address stable while idle.
- Read timing:
  - Read accepted in cycle N: the RAM latches the address at the end of N.
  - inflight=1 during N+1.
  - ram_dout is pushed into the FIFO at the end of N+1, together with the captured address.
  - rsp_valid=1 in cycle N+2 at the earliest.
- Write timing: the RAM is written at the end of the accept cycle; no response is generated unless the optional feature is enabled.
- Ordering: responses are strictly in request order, one request at most per cycle.
- Read-after-write, same address, consecutive cycles: the read returns the new data.
- Write-after-read, same address, consecutive cycles: the read returns the pre-write data. The capture register samples dout on the same edge the write lands.
- FIFO:
  - Circular buffer; each pointer wraps from RSP_DEPTH-1 to 0.
  - rsp_valid = (count != 0); rsp_data/rsp_addr/rsp_is_wr show the head entry.
  - Pop when rsp_valid & rsp_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Overflow is impossible because req_ready reserves space for the inflight entry.
  - rsp_ready while empty is ignored.
- Sustained throughput with rsp_ready=1 and RSP_DEPTH>=3: one request per cycle.

Optional Feature:
RAM_REQ_CTRL_WR_ACK_EN
- Defined: an accepted write occupies the inflight slot and pushes a response at the end of N+1.
  - Entry contents: rsp_is_wr=1, rsp_addr=write address, rsp_data=written data.
  - Writes are ordered with reads and counted in req_ready.
- Undefined: writes bypass the inflight stage and produce no response; rsp_is_wr is constant 0.
- req_ready uses the same formula in both builds.

Test Plan:
1. Assert reset_n=0 for 1 cycle while 3 read responses are buffered and 1 read is inflight -> rsp_valid=0 and req_ready=0 immediately; req_ready=1 in the first cycle after release; no stale response ever appears.
2. Write addr 3 = 0xDEADBEEF in cycle N, read addr 3 in N+1 -> rsp_valid=1 in N+3 with rsp_data=0xDEADBEEF, rsp_addr=3.
3. Preload mem[i]=i*0x11111111; read addrs 0..7 back-to-back with rsp_ready=1 -> req_ready stays 1; responses appear in cycles N+2..N+9 with data 0x00000000..0x77777777 in order.
4. With rsp_ready=0, issue continuous reads -> exactly 4 accepted, then req_ready=0; raise rsp_ready -> 4 responses drain in order and req_ready returns to 1 the cycle after the first pop.
5. mem[5]=0xAAAA0000; read addr 5 in N, write addr 5 = 0x00001234 in N+1 -> the response returns 0xAAAA0000; a later read of addr 5 returns 0x00001234.
6. With RAM_REQ_CTRL_WR_ACK_EN defined: write addr 2 = 0x55 in N -> in N+2, rsp_valid=1, rsp_is_wr=1, rsp_addr=2, rsp_data=0x55. Without the macro -> no response occurs.
